// File: rtl/fft_mag_streamer_pkg.sv
// Shared types and defaults for the FFT-magnitude streamer.
// Holds the default frame geometry, the complex-bin layout and the FSM state codes.
// Imported by the streamer top level and its testbench.
package fft_mag_streamer_pkg;

  localparam int CW_DEF       = 24;
  localparam int FFT_LEN_DEF  = 1024;
  localparam int NUM_BINS_DEF = 32;

  // Packed so that {re, im} lines up with the din data word (re in the upper half).
  typedef struct packed {
    logic signed [CW_DEF-1:0] re;
    logic signed [CW_DEF-1:0] im;
  } cbin_t;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_DROP   = 2'd1;
  localparam logic [1:0] ST_PAD    = 2'd2;

endpackage

// File: rtl/fft_mag_streamer_mag_sq_pipe.sv
// Three-stage |X|^2 pipe: S1 registers re/im, S2 squares, S3 sums and saturates.
// Latency 3 cycles with the sink ready; 1 bin/clk throughput.
// Backpressure: each stage advances when empty or when the next stage accepts, so bubbles collapse.
module mag_sq_pipe #(
  parameter int CW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bin_valid,
  output logic                 bin_ready,
  input  logic signed [CW-1:0] bin_re,
  input  logic signed [CW-1:0] bin_im,
  input  logic                 bin_tag,
  output logic                 mag_valid,
  input  logic                 mag_ready,
  output logic [2*CW-1:0]      mag_data,
  output logic                 mag_tag
);

  localparam int PW = 2 * CW;
  localparam logic signed [CW-1:0] MIN_VAL = {1'b1, {(CW-1){1'b0}}};

  logic                 s1_valid;
  logic signed [CW-1:0] s1_re;
  logic signed [CW-1:0] s1_im;
  logic                 s1_tag;

  logic                 s2_valid;
  logic [PW-1:0]        s2_re_sq;
  logic [PW-1:0]        s2_im_sq;
  logic                 s2_clip;
  logic                 s2_tag;

  logic                 s3_valid;
  logic [PW-1:0]        s3_data;
  logic                 s3_tag;

  logic                 adv1;
  logic                 adv2;
  logic                 adv3;
  logic signed [PW-1:0] re_prod;
  logic signed [PW-1:0] im_prod;
  logic [PW:0]          sum;

  assign adv3 = !s3_valid || mag_ready;
  assign adv2 = !s2_valid || adv3;
  assign adv1 = !s1_valid || adv2;

  assign bin_ready = adv1;
  assign mag_valid = s3_valid;
  assign mag_data  = s3_data;
  assign mag_tag   = s3_tag;

  assign re_prod = PW'(s1_re) * PW'(s1_re);
  assign im_prod = PW'(s1_im) * PW'(s1_im);
  assign sum     = {1'b0, s2_re_sq} + {1'b0, s2_im_sq};

  // S1: capture the incoming complex bin and its tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_tag   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bin_valid;
      if (bin_valid) begin
        s1_re  <= bin_re;
        s1_im  <= bin_im;
        s1_tag <= bin_tag;
      end
    end
  end

  // S2: both squares, plus a flag for the both-full-scale-negative corner, which is reported as clipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_re_sq <= '0;
      s2_im_sq <= '0;
      s2_clip  <= 1'b0;
      s2_tag   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_re_sq <= $unsigned(re_prod);
        s2_im_sq <= $unsigned(im_prod);
        s2_clip  <= (s1_re == MIN_VAL) && (s1_im == MIN_VAL);
        s2_tag   <= s1_tag;
      end
    end
  end

  // S3: sum at 2*CW+1 bits and saturate into the 2*CW-bit output; holds while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_tag   <= 1'b0;
    end else if (adv3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_data <= (s2_clip || sum[PW]) ? {PW{1'b1}} : sum[PW-1:0];
        s3_tag  <= s2_tag;
      end
    end
  end

endmodule

// File: rtl/fft_mag_streamer.sv
// Forwards |X|^2 of the lowest NUM_BINS bins of each FFT frame, with a marker on the last forwarded bin.
// Latency 3 cycles din accept to dout; long frames are trimmed, short frames are zero-padded.
// Backpressure: din_ready follows the squaring pipe while accepting, is high while dropping, low while padding.
module fft_mag_streamer
  import fft_mag_streamer_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int FFT_LEN  = FFT_LEN_DEF,
  parameter int NUM_BINS = NUM_BINS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [2*CW-1:0] din_data,
  input  logic            din_last,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [2*CW-1:0] dout_data,
  output logic            dout_last,
  output logic            frame_err
);

  localparam int BIN_W = $clog2(FFT_LEN);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0] END_BIN  = BIN_W'(FFT_LEN - 1);
  localparam bit FULL = (NUM_BINS == FFT_LEN);

  logic [1:0]           state;
  logic [BIN_W-1:0]     bin_cnt;
  logic [BIN_W-1:0]     pad_cnt;

  logic                 pipe_valid;
  logic                 pipe_ready;
  logic signed [CW-1:0] pipe_re;
  logic signed [CW-1:0] pipe_im;
  logic                 pipe_tag;
  logic                 din_fire;

  assign din_fire = din_valid && din_ready;

  // Steer the pipe input between live bins and injected zero bins, and derive din_ready per state.
  always_comb begin
    din_ready  = 1'b0;
    pipe_valid = 1'b0;
    pipe_re    = '0;
    pipe_im    = '0;
    pipe_tag   = 1'b0;
    case (state)
      ST_ACCEPT: begin
        din_ready  = pipe_ready;
        pipe_valid = din_valid;
        pipe_re    = din_data[2*CW-1:CW];
        pipe_im    = din_data[CW-1:0];
        pipe_tag   = (bin_cnt == LAST_BIN);
      end
      ST_DROP: begin
        din_ready = 1'b1;
      end
      ST_PAD: begin
        pipe_valid = 1'b1;
        pipe_tag   = (pad_cnt == LAST_BIN);
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
    if (reset) begin
      din_ready = 1'b0;
    end
  end

  // Frame FSM: count accepted bins, trim long frames, pad short ones, flag length violations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ACCEPT;
      bin_cnt   <= '0;
      pad_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (din_fire) begin
            if (din_last) begin
              bin_cnt <= '0;
              if (bin_cnt < LAST_BIN) begin
                state     <= ST_PAD;
                pad_cnt   <= bin_cnt + 1'b1;
                frame_err <= 1'b1;
              end else begin
                // All forwarded bins arrived, but the frame ended before FFT_LEN bins.
                frame_err <= !FULL;
              end
            end else if (bin_cnt == LAST_BIN) begin
              if (FULL) begin
                bin_cnt   <= '0;
                frame_err <= 1'b1;
              end else begin
                state   <= ST_DROP;
                bin_cnt <= bin_cnt + 1'b1;
              end
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (din_fire) begin
            if (din_last) begin
              state     <= ST_ACCEPT;
              bin_cnt   <= '0;
              frame_err <= (bin_cnt != END_BIN);
            end else if (bin_cnt == END_BIN) begin
              // Missing last: resynchronise so the next beat is bin 0.
              state     <= ST_ACCEPT;
              bin_cnt   <= '0;
              frame_err <= 1'b1;
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
            end
          end
        end
        ST_PAD: begin
          if (pipe_ready) begin
            if (pad_cnt == LAST_BIN) begin
              state   <= ST_ACCEPT;
              bin_cnt <= '0;
            end else begin
              pad_cnt <= pad_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_ACCEPT;
          bin_cnt <= '0;
        end
      endcase
    end
  end

  mag_sq_pipe #(
    .CW (CW)
  ) u_pipe (
    .clk       (clk),
    .rst       (reset),
    .bin_valid (pipe_valid),
    .bin_ready (pipe_ready),
    .bin_re    (pipe_re),
    .bin_im    (pipe_im),
    .bin_tag   (pipe_tag),
    .mag_valid (dout_valid),
    .mag_ready (dout_ready),
    .mag_data  (dout_data),
    .mag_tag   (dout_last)
  );

endmodule
